// File: rtl/candy_seq_pkg.sv
// candy_seq_pkg: shared definitions for the candy core control sequencer.
//   - 3-bit state encoding constants (IDLE..FAULT) and their width
//   - stage-enable vector layout {fetch, decode, exec, mem, wb}
//   - helpers mapping a state to its Moore stage enables and wait-state flag
package candy_seq_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned EN_W    = 5;

  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_FETCH  = 3'd1;
  localparam logic [STATE_W-1:0] ST_DECODE = 3'd2;
  localparam logic [STATE_W-1:0] ST_EXEC   = 3'd3;
  localparam logic [STATE_W-1:0] ST_MEM    = 3'd4;
  localparam logic [STATE_W-1:0] ST_WB     = 3'd5;
  localparam logic [STATE_W-1:0] ST_HALT   = 3'd6;
  localparam logic [STATE_W-1:0] ST_FAULT  = 3'd7;

  // Bit positions inside the stage-enable vector.
  localparam int unsigned EN_FETCH  = 4;
  localparam int unsigned EN_DECODE = 3;
  localparam int unsigned EN_EXEC   = 2;
  localparam int unsigned EN_MEM    = 1;
  localparam int unsigned EN_WB     = 0;

  // One-hot stage enable for a state; all-zero in IDLE/HALT/FAULT.
  function automatic logic [EN_W-1:0] stage_enables(input logic [STATE_W-1:0] s);
    logic [EN_W-1:0] en;
    en = '0;
    case (s)
      ST_FETCH:  en[EN_FETCH]  = 1'b1;
      ST_DECODE: en[EN_DECODE] = 1'b1;
      ST_EXEC:   en[EN_EXEC]   = 1'b1;
      ST_MEM:    en[EN_MEM]    = 1'b1;
      ST_WB:     en[EN_WB]     = 1'b1;
      default:   en            = '0;
    endcase
    return en;
  endfunction

  // States that wait on the SRAM ready handshake.
  function automatic logic is_wait_state(input logic [STATE_W-1:0] s);
    return (s == ST_FETCH) || (s == ST_MEM);
  endfunction

endpackage

// File: rtl/candy_seq_timer.sv
// candy_seq_timer: wait/timeout counter for the FETCH/MEM ready handshake.
// Ports:
//   clk, rst    clock, asynchronous active-low reset
//   clear       hold the count at zero (asserted outside wait states)
//   inc         one more not-ready cycle elapsed
//   timeout_c   count has reached MEM_TIMEOUT (combinational from the count)
module candy_seq_timer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic timeout_c
);

  localparam int unsigned CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_TIMEOUT);

  logic [CNT_W-1:0] count;

  // Counter stops at LIMIT so it can never wrap back below the threshold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != LIMIT)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign timeout_c = (count == LIMIT);

endmodule

// File: rtl/candy_seq.sv
// candy_seq: multi-cycle control sequencer for the candy core.
// Walks FETCH -> DECODE -> EXEC -> [MEM] -> WB with a ready handshake and
// timeout on the memory stages, stall in DECODE/EXEC, halt/resume after WB,
// branch-aware PC update and a saturating retired-instruction counter.
// Ports:
//   clk, rst               clock, asynchronous active-low reset
//   mem_ready_i            SRAM access complete (FETCH/MEM)
//   is_mem_i               instruction needs MEM stage (sampled in EXEC)
//   branch_taken_i/target  PC redirect (sampled in WB)
//   stall_i                hold in DECODE/EXEC
//   halt_i / resume_i      enter HALT after WB / leave HALT
//   pc_o                   current instruction address
//   *_en_o                 one-hot Moore stage enables
//   retire_o               high during the WB cycle
//   halted_o / fault_o     in HALT / memory timeout (sticky)
//   state_o                current state encoding
//   inst_count_o           saturating retired-instruction count
module candy_seq
  import candy_seq_pkg::*;
#(
  parameter int unsigned        ADDR_W      = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC    = '0,
  parameter int unsigned        PC_STEP     = 1,
  parameter int unsigned        MEM_TIMEOUT = 15,
  parameter int unsigned        COUNT_W     = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_ready_i,
  input  logic               is_mem_i,
  input  logic               branch_taken_i,
  input  logic [ADDR_W-1:0]  branch_target_i,
  input  logic               stall_i,
  input  logic               halt_i,
  input  logic               resume_i,
  output logic [ADDR_W-1:0]  pc_o,
  output logic               fetch_en_o,
  output logic               decode_en_o,
  output logic               exec_en_o,
  output logic               mem_en_o,
  output logic               wb_en_o,
  output logic               retire_o,
  output logic               halted_o,
  output logic               fault_o,
  output logic [STATE_W-1:0] state_o,
  output logic [COUNT_W-1:0] inst_count_o
);

  localparam logic [ADDR_W-1:0]  STEP      = ADDR_W'(PC_STEP);
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_next;
  logic [EN_W-1:0]    en_next;
  logic               retire_next;
  logic               halted_next;
  logic               fault_next;
  logic [ADDR_W-1:0]  pc_next;
  logic [COUNT_W-1:0] count_next;
  logic               tmr_clear;
  logic               tmr_inc;
  logic               tmr_timeout_c;

  // Wait counter is held at zero outside FETCH/MEM, so every entry starts clean.
  assign tmr_clear = !is_wait_state(state);
  assign tmr_inc   = is_wait_state(state) && !mem_ready_i;

  candy_seq_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clear     (tmr_clear),
    .inc       (tmr_inc),
    .timeout_c (tmr_timeout_c)
  );

  // Next-state and next-output logic; outputs are registered from the next state.
  always_comb begin
    state_next  = state;
    pc_next     = pc_o;
    count_next  = inst_count_o;

    case (state)
      ST_IDLE:   state_next = ST_FETCH;
      ST_FETCH: begin
        // Ready wins over a timeout in the same cycle.
        if (mem_ready_i)        state_next = ST_DECODE;
        else if (tmr_timeout_c) state_next = ST_FAULT;
      end
      ST_DECODE: if (!stall_i) state_next = ST_EXEC;
      ST_EXEC:   if (!stall_i) state_next = is_mem_i ? ST_MEM : ST_WB;
      ST_MEM: begin
        if (mem_ready_i)        state_next = ST_WB;
        else if (tmr_timeout_c) state_next = ST_FAULT;
      end
      ST_WB: begin
        state_next = halt_i ? ST_HALT : ST_FETCH;
        // WB always exits after one cycle: update PC and count here.
        pc_next    = branch_taken_i ? branch_target_i : pc_o + STEP;
        if (inst_count_o != COUNT_MAX) count_next = inst_count_o + COUNT_W'(1);
      end
      ST_HALT:   if (resume_i) state_next = ST_FETCH;
      ST_FAULT:  state_next = ST_FAULT;
      default:   state_next = ST_IDLE;
    endcase

    en_next     = stage_enables(state_next);
    retire_next = (state_next == ST_WB);
    halted_next = (state_next == ST_HALT);
    fault_next  = fault_o || (state_next == ST_FAULT);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      pc_o         <= RESET_PC;
      fetch_en_o   <= 1'b0;
      decode_en_o  <= 1'b0;
      exec_en_o    <= 1'b0;
      mem_en_o     <= 1'b0;
      wb_en_o      <= 1'b0;
      retire_o     <= 1'b0;
      halted_o     <= 1'b0;
      fault_o      <= 1'b0;
      inst_count_o <= '0;
    end else begin
      state        <= state_next;
      pc_o         <= pc_next;
      fetch_en_o   <= en_next[EN_FETCH];
      decode_en_o  <= en_next[EN_DECODE];
      exec_en_o    <= en_next[EN_EXEC];
      mem_en_o     <= en_next[EN_MEM];
      wb_en_o      <= en_next[EN_WB];
      retire_o     <= retire_next;
      halted_o     <= halted_next;
      fault_o      <= fault_next;
      inst_count_o <= count_next;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_candy_seq.sv
// tb_candy_seq: self-checking bench for candy_seq.
// Two instances: "A" (ADDR_W=16, RESET_PC=0x0100, MEM_TIMEOUT=15, COUNT_W=32)
// and "B" (ADDR_W=4, RESET_PC=0xE, MEM_TIMEOUT=3, COUNT_W=2). Inputs are shared;
// the instance not under test is held in reset. Each instruction is described
// by phase lengths, the expected state trace is built from those lengths and
// PC/count are tracked with plain arithmetic.
module tb_candy_seq;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3;
  localparam logic [2:0] S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6, S_FAULT = 3'd7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, sel_b;
  logic        mem_ready, is_mem, branch_taken, stall, halt, resume;
  logic [15:0] branch_target;

  logic [15:0] pc_a;  logic [2:0] st_a; logic [31:0] cnt_a;
  logic        fe_a, de_a, ex_a, me_a, wb_a, ret_a, hlt_a, flt_a;
  logic [3:0]  pc_b;  logic [2:0] st_b; logic [1:0]  cnt_b;
  logic        fe_b, de_b, ex_b, me_b, wb_b, ret_b, hlt_b, flt_b;

  candy_seq #(.ADDR_W(16), .RESET_PC(16'h0100), .PC_STEP(1), .MEM_TIMEOUT(15), .COUNT_W(32)) u_dut_a (
    .clk(clk), .rst(rst_a), .mem_ready_i(mem_ready), .is_mem_i(is_mem),
    .branch_taken_i(branch_taken), .branch_target_i(branch_target), .stall_i(stall),
    .halt_i(halt), .resume_i(resume), .pc_o(pc_a), .fetch_en_o(fe_a), .decode_en_o(de_a),
    .exec_en_o(ex_a), .mem_en_o(me_a), .wb_en_o(wb_a), .retire_o(ret_a), .halted_o(hlt_a),
    .fault_o(flt_a), .state_o(st_a), .inst_count_o(cnt_a));

  candy_seq #(.ADDR_W(4), .RESET_PC(4'hE), .PC_STEP(1), .MEM_TIMEOUT(3), .COUNT_W(2)) u_dut_b (
    .clk(clk), .rst(rst_b), .mem_ready_i(mem_ready), .is_mem_i(is_mem),
    .branch_taken_i(branch_taken), .branch_target_i(branch_target[3:0]), .stall_i(stall),
    .halt_i(halt), .resume_i(resume), .pc_o(pc_b), .fetch_en_o(fe_b), .decode_en_o(de_b),
    .exec_en_o(ex_b), .mem_en_o(me_b), .wb_en_o(wb_b), .retire_o(ret_b), .halted_o(hlt_b),
    .fault_o(flt_b), .state_o(st_b), .inst_count_o(cnt_b));

  // Observation mux onto the instance under test.
  logic [2:0]  o_state;
  logic [4:0]  o_en;
  logic        o_ret, o_hlt, o_flt;
  logic [15:0] o_pc;
  logic [31:0] o_cnt;
  always_comb begin
    if (sel_b) begin
      o_state = st_b; o_en = {fe_b, de_b, ex_b, me_b, wb_b};
      o_ret = ret_b; o_hlt = hlt_b; o_flt = flt_b;
      o_pc = {12'd0, pc_b}; o_cnt = {30'd0, cnt_b};
    end else begin
      o_state = st_a; o_en = {fe_a, de_a, ex_a, me_a, wb_a};
      o_ret = ret_a; o_hlt = hlt_a; o_flt = flt_a;
      o_pc = pc_a; o_cnt = cnt_a;
    end
  end

  int          checks = 0;
  int          errors = 0;
  int unsigned m_pc, m_cnt, m_mask, m_cmax, m_tmo;

  function automatic logic [4:0] en_of(input logic [2:0] s);
    case (s)
      S_FETCH:  return 5'b10000;
      S_DECODE: return 5'b01000;
      S_EXEC:   return 5'b00100;
      S_MEM:    return 5'b00010;
      S_WB:     return 5'b00001;
      default:  return 5'b00000;
    endcase
  endfunction

  task automatic rand_in();
    mem_ready     = 1'($urandom);
    is_mem        = 1'($urandom);
    branch_taken  = 1'($urandom);
    branch_target = 16'($urandom);
    stall         = 1'($urandom);
    halt          = 1'($urandom);
    resume        = 1'($urandom);
  endtask

  // Advance one cycle (inputs already driven) and compare against the model.
  task automatic run_cycle(input logic [2:0] es);
    @(negedge clk);
    checks++; if (o_state !== es) begin errors++;
      $display("FAIL state t=%0t got %0d want %0d", $time, o_state, es); end
    checks++; if (o_en !== en_of(es)) begin errors++;
      $display("FAIL enables t=%0t got %b want %b", $time, o_en, en_of(es)); end
    checks++; if (o_ret !== (es == S_WB)) begin errors++;
      $display("FAIL retire t=%0t got %b want %b", $time, o_ret, es == S_WB); end
    checks++; if (o_hlt !== (es == S_HALT)) begin errors++;
      $display("FAIL halted t=%0t got %b want %b", $time, o_hlt, es == S_HALT); end
    checks++; if (o_flt !== (es == S_FAULT)) begin errors++;
      $display("FAIL fault t=%0t got %b want %b", $time, o_flt, es == S_FAULT); end
    checks++; if (o_pc !== m_pc[15:0]) begin errors++;
      $display("FAIL pc t=%0t got %h want %h", $time, o_pc, m_pc[15:0]); end
    checks++; if (o_cnt !== m_cnt) begin errors++;
      $display("FAIL inst_count t=%0t got %0d want %0d", $time, o_cnt, m_cnt); end
    @(posedge clk); #1;
  endtask

  // Assert reset mid-cycle, check values immediately, release, check IDLE cycle.
  task automatic do_reset(input bit b);
    logic [15:0] rpc;
    #2;
    sel_b = b;
    rst_a = 1'b0; rst_b = 1'b0;
    rpc = b ? 16'h000E : 16'h0100;
    #1;
    checks++; if (o_state !== S_IDLE) begin errors++;
      $display("FAIL reset_state got %0d want 0", o_state); end
    checks++; if ({o_en, o_ret, o_hlt, o_flt} !== 8'd0) begin errors++;
      $display("FAIL reset_flags got %b want 0", {o_en, o_ret, o_hlt, o_flt}); end
    checks++; if (o_pc !== rpc) begin errors++;
      $display("FAIL reset_pc got %h want %h", o_pc, rpc); end
    checks++; if (o_cnt !== 32'd0) begin errors++;
      $display("FAIL reset_count got %0d want 0", o_cnt); end
    @(posedge clk); #1;
    if (b) rst_b = 1'b1; else rst_a = 1'b1;
    m_pc   = 32'(rpc);
    m_cnt  = 0;
    m_mask = b ? 32'h0000_000F : 32'h0000_FFFF;
    m_cmax = b ? 32'd3 : 32'hFFFF_FFFF;
    m_tmo  = b ? 32'd3 : 32'd15;
    rand_in();
    run_cycle(S_IDLE);
  endtask

  // One instruction: fw/mw not-ready cycles before ready, ds/es stall cycles.
  task automatic run_instr(input int fw, input int ds, input int es, input bit mem,
                           input int mw, input bit br, input logic [15:0] tgt,
                           input bit hlt, input int hc);
    for (int i = 0; i <= fw; i++) begin rand_in(); mem_ready = (i == fw); run_cycle(S_FETCH); end
    for (int i = 0; i <= ds; i++) begin rand_in(); stall = (i < ds); run_cycle(S_DECODE); end
    for (int i = 0; i <= es; i++) begin rand_in(); stall = (i < es); is_mem = mem; run_cycle(S_EXEC); end
    if (mem)
      for (int i = 0; i <= mw; i++) begin rand_in(); mem_ready = (i == mw); run_cycle(S_MEM); end
    rand_in(); branch_taken = br; branch_target = tgt; halt = hlt;
    run_cycle(S_WB);
    m_pc = br ? (32'(tgt) & m_mask) : ((m_pc + 1) & m_mask);
    if (m_cnt != m_cmax) m_cnt++;
    if (hlt)
      for (int i = 0; i < hc; i++) begin rand_in(); resume = (i == hc - 1); run_cycle(S_HALT); end
  endtask

  task automatic test_reset();
    do_reset(1'b0);
  endtask

  task automatic test_basic();
    for (int n = 0; n < 3; n++) run_instr(0, 0, 0, 1'b0, 0, 1'b0, 16'h0, 1'b0, 0);
    checks++; if (o_cnt !== 32'd3 || o_pc !== 16'h0103) begin errors++;
      $display("FAIL basic_summary got cnt %0d pc %h want 3 0103", o_cnt, o_pc); end
  endtask

  task automatic test_mem_wait();
    run_instr(0, 0, 0, 1'b1, 3, 1'b0, 16'h0, 1'b0, 0);
    run_instr(0, 0, 0, 1'b1, 0, 1'b0, 16'h0, 1'b0, 0);
    // Ready arriving exactly at the timeout count still wins.
    run_instr(int'(m_tmo), 0, 0, 1'b1, int'(m_tmo), 1'b0, 16'h0, 1'b0, 0);
  endtask

  task automatic test_branch_wrap();
    run_instr(0, 0, 0, 1'b0, 0, 1'b1, 16'hFFFF, 1'b0, 0);
    run_instr(0, 0, 0, 1'b0, 0, 1'b0, 16'h0, 1'b0, 0);
    run_instr(0, 0, 0, 1'b0, 0, 1'b1, 16'h0005, 1'b0, 0);
  endtask

  task automatic test_stall_halt();
    run_instr(0, 2, 5, 1'b0, 0, 1'b1, 16'h1234, 1'b1, 3);
    run_instr(1, 0, 5, 1'b1, 1, 1'b0, 16'h0, 1'b1, 1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int fw, mw;
      fw = ($urandom_range(0, 7) == 0) ? int'(m_tmo) : int'($urandom_range(0, 3));
      mw = ($urandom_range(0, 7) == 0) ? int'(m_tmo) : int'($urandom_range(0, 3));
      run_instr(fw, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                1'($urandom), mw, $urandom_range(0, 3) == 0, 16'($urandom),
                $urandom_range(0, 4) == 0, int'($urandom_range(1, 3)));
    end
  endtask

  task automatic test_async_reset();
    rand_in(); mem_ready = 1'b1; run_cycle(S_FETCH);
    rand_in(); stall = 1'b0; run_cycle(S_DECODE);
    rand_in(); stall = 1'b0; is_mem = 1'b0; run_cycle(S_EXEC);
    checks++; if (o_ret !== 1'b1) begin errors++;
      $display("FAIL wb_before_reset got %b want 1", o_ret); end
    do_reset(1'b0);
    run_instr(0, 0, 0, 1'b0, 0, 1'b0, 16'h0, 1'b0, 0);
  endtask

  task automatic test_small_wrap_saturate();
    do_reset(1'b1);
    for (int n = 0; n < 5; n++) run_instr(0, 0, 0, 1'($urandom), 0, 1'b0, 16'h0, 1'b0, 0);
    checks++; if (o_cnt !== 32'd3 || o_pc !== 16'h0003) begin errors++;
      $display("FAIL small_summary got cnt %0d pc %h want 3 0003", o_cnt, o_pc); end
    run_instr(3, 0, 0, 1'b1, 3, 1'b1, 16'hABC5, 1'b0, 0);
  endtask

  task automatic test_fault_fetch();
    do_reset(1'b1);
    for (int i = 0; i <= int'(m_tmo); i++) begin rand_in(); mem_ready = 1'b0; run_cycle(S_FETCH); end
    for (int i = 0; i < 4; i++) begin rand_in(); mem_ready = 1'b1; resume = 1'b1; run_cycle(S_FAULT); end
  endtask

  task automatic test_fault_mem();
    do_reset(1'b1);
    rand_in(); mem_ready = 1'b1; run_cycle(S_FETCH);
    rand_in(); stall = 1'b0; run_cycle(S_DECODE);
    rand_in(); stall = 1'b0; is_mem = 1'b1; run_cycle(S_EXEC);
    for (int i = 0; i <= int'(m_tmo); i++) begin rand_in(); mem_ready = 1'b0; run_cycle(S_MEM); end
    for (int i = 0; i < 3; i++) begin rand_in(); run_cycle(S_FAULT); end
    do_reset(1'b1);
    run_instr(1, 0, 0, 1'b1, 2, 1'b0, 16'h0, 1'b0, 0);
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; sel_b = 1'b0;
    mem_ready = 1'b0; is_mem = 1'b0; branch_taken = 1'b0; branch_target = '0;
    stall = 1'b0; halt = 1'b0; resume = 1'b0;
    m_pc = 0; m_cnt = 0; m_mask = 32'hFFFF; m_cmax = 32'hFFFF_FFFF; m_tmo = 15;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_mem_wait();
    test_branch_wrap();
    test_stall_halt();
    test_random();
    test_async_reset();
    test_small_wrap_saturate();
    test_fault_fetch();
    test_fault_mem();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
